multiport_register_file: RTL and testbench
==========================================

// Module: multiport_register_file
// PURPOSE
//  Parametrised successor register file for the pipelined datapath: NUM_READ combinational read ports,
//  two synchronous write ports (ALU writeback A, load/mult writeback B) and a per-register busy scoreboard
//  used by the hazard unit to stall. Register 0 reads zero and ignores writes. Sits between decode (reads,
//  reservations) and writeback (writes) stages; optional same-cycle write-to-read forwarding.
// PARAMETERS
//  WORD_LENGTH  32                 data width in bits
//  ID_LENGTH    5                  register index width
//  NUM_REGS     2**ID_LENGTH       number of registers (<= 2**ID_LENGTH; indices >= NUM_REGS are ignored)
//  NUM_READ     2                  number of read ports (1..4)
// PORTS
//  clk        in   1                      clock, all state on rising edge
//  rst        in   1                      reset, asynchronous, active-high
//  rd_addr    in   NUM_READ*ID_LENGTH     read indices, port k at [k*ID_LENGTH +: ID_LENGTH]
//  rd_data    out  NUM_READ*WORD_LENGTH   read data, port k at [k*WORD_LENGTH +: WORD_LENGTH]
//  rd_busy    out  NUM_READ               1 = register at port k has a pending producer
//  wa_en      in   1                      write port A enable
//  wa_addr    in   ID_LENGTH              write port A index
//  wa_data    in   WORD_LENGTH            write port A data
//  wb_en      in   1                      write port B enable
//  wb_addr    in   ID_LENGTH              write port B index
//  wb_data    in   WORD_LENGTH            write port B data
//  rsv_en     in   1                      reserve (mark busy) request from decode
//  rsv_addr   in   ID_LENGTH              register to reserve
//  busy_cnt   out  ID_LENGTH+1            number of registers currently busy
//  wr_err     out  1                      sticky: write to a register that was not busy
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-write): all registers 0, all busy bits 0, busy_cnt 0, wr_err 0.
//  - Reads: combinational, zero latency; index 0 or >= NUM_REGS returns 0 and rd_busy 0.
//  - Writes: registered on rising clk; data visible on rd_data the cycle after the edge.
//  - Writes to index 0 or >= NUM_REGS are dropped, clear nothing, and do not set wr_err.
//  - wa_en & wb_en to the same index in one cycle: port A data wins; busy bit cleared once.
//  - Scoreboard: rsv_en sets busy[rsv_addr] at next edge; an accepted write clears busy[addr].
//  - rsv_en and write to same index in same cycle: reservation wins (busy stays 1, data still written),
//    since the reservation is a younger producer.
//  - Reserving an already-busy register: busy stays 1, busy_cnt unchanged. rsv_addr 0 ignored.
//  - busy_cnt = popcount of busy bits, updated registered, consistent with busy bits every cycle.
//  - wr_err set at edge when an enabled write hits a valid nonzero index whose busy bit is 0 and which
//    is not reserved in that same cycle; cleared only by rst.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: a read whose index matches an enabled write in the same cycle returns the
//    write data (port A over B) and rd_busy reports 0 unless rsv_en targets that index that cycle.
//  REGFILE_BYPASS_EN undefined: reads return stored value and stored busy bit only; the hazard unit
//    must stall one extra cycle after writeback.
// TESTING
//  1 rst mid-run after writing R5=0xDEAD -> all rd_data 0, busy_cnt 0, wr_err 0 immediately (no clk).
//  2 wa R3=0x1234, then rd_addr0=3 -> 0x1234 next cycle; wa R0=0xFFFF -> R0 still reads 0.
//  3 wa R7=0xAAAA and wb R7=0x5555 same cycle -> R7 reads 0xAAAA; wb R8=0x5555 alone -> 0x5555.
//  4 rsv R4 -> rd_busy 1, busy_cnt 1; wa R4=0x42 -> busy 0, busy_cnt 0; rsv+wa R4 same cycle -> busy 1.
//  5 wb R9=0x1 with R9 not busy -> wr_err 1 and stays 1 until rst.
//  6 REGFILE_BYPASS_EN: wa R2=0x77 while rd_addr1=2 -> rd_data port1 0x77 same cycle; without macro
//    -> old value that cycle, 0x77 next cycle.

Source files
------------

// File: rtl/multiport_register_file.sv
// -----------------------------------------------------------------------------
// multiport_register_file
//
// Register file for the pipelined datapath.
//   * NUM_READ combinational read ports.
//   * Two synchronous write ports: A (ALU writeback) and B (load/mult
//     writeback).
//   * A per-register busy scoreboard that the hazard unit uses to stall.
//   * Register 0 always reads zero and ignores writes.
//   * Indices >= NUM_REGS read as zero, and writes to them are dropped.
//
// Optional feature (compile-time macro REGFILE_BYPASS_EN):
//   When defined, a read whose index matches an enabled, accepted write in the
//   same cycle returns the write data (port A has priority over port B). In
//   that case rd_busy reads 0, unless the same index is being reserved in that
//   cycle. When undefined, reads return only the stored value and the stored
//   busy bit.
//
// Ports
//   clk       in   clock; all state updates on the rising edge
//   rst       in   asynchronous, active-high reset (clears data and scoreboard)
//   rd_addr   in   NUM_READ*ID_LENGTH; port k index at [k*ID_LENGTH +: ID_LENGTH]
//   rd_data   out  NUM_READ*WORD_LENGTH; port k data at [k*WORD_LENGTH +: WORD_LENGTH]
//   rd_busy   out  NUM_READ; 1 = register read by port k has a pending producer
//   wa_en     in   write port A enable
//   wa_addr   in   write port A index
//   wa_data   in   write port A data
//   wb_en     in   write port B enable
//   wb_addr   in   write port B index
//   wb_data   in   write port B data
//   rsv_en    in   reserve request from decode (marks a register busy)
//   rsv_addr  in   register to reserve
//   busy_cnt  out  number of registers currently busy
//   wr_err    out  sticky flag: a write hit a register that was not busy
// -----------------------------------------------------------------------------
module multiport_register_file #(
  parameter int WORD_LENGTH = 32,
  parameter int ID_LENGTH   = 5,
  parameter int NUM_REGS    = 2**ID_LENGTH,
  parameter int NUM_READ    = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_READ*ID_LENGTH-1:0]   rd_addr,
  output logic [NUM_READ*WORD_LENGTH-1:0] rd_data,
  output logic [NUM_READ-1:0]             rd_busy,
  input  logic                            wa_en,
  input  logic [ID_LENGTH-1:0]            wa_addr,
  input  logic [WORD_LENGTH-1:0]          wa_data,
  input  logic                            wb_en,
  input  logic [ID_LENGTH-1:0]            wb_addr,
  input  logic [WORD_LENGTH-1:0]          wb_data,
  input  logic                            rsv_en,
  input  logic [ID_LENGTH-1:0]            rsv_addr,
  output logic [ID_LENGTH:0]              busy_cnt,
  output logic                            wr_err
);

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // True for an index that names a real, writable register
  // (nonzero and below NUM_REGS).
  function automatic logic idx_ok(input logic [ID_LENGTH-1:0] a);
    return (a != '0) && (int'(a) < NUM_REGS);
  endfunction

  // Number of set bits in a busy vector.
  function automatic logic [ID_LENGTH:0] popcount(input logic [NUM_REGS-1:0] b);
    logic [ID_LENGTH:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt = cnt + (ID_LENGTH+1)'(b[i]);
    end
    return cnt;
  endfunction

  // Stored busy bit of an index. Out-of-range indices read as 0.
  function automatic logic busy_of(input logic [NUM_REGS-1:0] b,
                                   input logic [ID_LENGTH-1:0] a);
    logic r;
    r = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (a == ID_LENGTH'(i)) r = b[i];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Architectural state
  // ---------------------------------------------------------------------------
  logic [WORD_LENGTH-1:0] regs_p1 [NUM_REGS];
  logic [NUM_REGS-1:0]    busy_p1;
  logic [ID_LENGTH:0]     busy_cnt_p1;
  logic                   err_p1;

  // Qualified requests: enable AND a legal target index.
  logic wa_vld_p0, wb_vld_p0, rsv_vld_p0;
  logic [NUM_REGS-1:0] busy_d;
  logic                err_d;

  assign wa_vld_p0  = wa_en  && idx_ok(wa_addr);
  assign wb_vld_p0  = wb_en  && idx_ok(wb_addr);
  assign rsv_vld_p0 = rsv_en && idx_ok(rsv_addr);

  // ---------------------------------------------------------------------------
  // Next-state scoreboard and error detection
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_d = busy_p1;
    for (int i = 1; i < NUM_REGS; i++) begin
      // A same-cycle reservation belongs to a younger producer,
      // so it overrides the clear caused by a write.
      if (rsv_vld_p0 && rsv_addr == ID_LENGTH'(i)) begin
        busy_d[i] = 1'b1;
      end else if ((wa_vld_p0 && wa_addr == ID_LENGTH'(i)) ||
                   (wb_vld_p0 && wb_addr == ID_LENGTH'(i))) begin
        busy_d[i] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;

    // A write is an error when it has no outstanding producer and is not
    // covered by a reservation made in the same cycle.
    err_d = 1'b0;
    if (wa_vld_p0 && !busy_of(busy_p1, wa_addr) &&
        !(rsv_vld_p0 && rsv_addr == wa_addr)) begin
      err_d = 1'b1;
    end
    if (wb_vld_p0 && !busy_of(busy_p1, wb_addr) &&
        !(rsv_vld_p0 && rsv_addr == wb_addr)) begin
      err_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State update on the clock edge
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_p1[i] <= '0;
      end
      busy_p1     <= '0;
      busy_cnt_p1 <= '0;
      err_p1      <= 1'b0;
    end else begin
      // Register 0 is never written, so it keeps its reset value of zero.
      for (int i = 1; i < NUM_REGS; i++) begin
        // Port A has priority when both ports target the same register.
        if (wa_vld_p0 && wa_addr == ID_LENGTH'(i)) begin
          regs_p1[i] <= wa_data;
        end else if (wb_vld_p0 && wb_addr == ID_LENGTH'(i)) begin
          regs_p1[i] <= wb_data;
        end
      end
      busy_p1     <= busy_d;
      // The count is taken from the same next-state vector,
      // so it always agrees with busy_p1.
      busy_cnt_p1 <= popcount(busy_d);
      err_p1      <= err_p1 | err_d;
    end
  end

  assign busy_cnt = busy_cnt_p1;
  assign wr_err   = err_p1;

  // ---------------------------------------------------------------------------
  // Combinational read ports
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [ID_LENGTH-1:0]   a;
    logic [WORD_LENGTH-1:0] d;
    logic                   bz;
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      a  = rd_addr[k*ID_LENGTH +: ID_LENGTH];
      d  = '0;
      bz = 1'b0;
      if (idx_ok(a)) begin
        for (int i = 1; i < NUM_REGS; i++) begin
          if (a == ID_LENGTH'(i)) begin
            d  = regs_p1[i];
            bz = busy_p1[i];
          end
        end
`ifdef REGFILE_BYPASS_EN
        // Port B is checked first, so port A overrides it on a double hit.
        if (wb_vld_p0 && wb_addr == a) begin
          d  = wb_data;
          bz = rsv_vld_p0 && rsv_addr == a;
        end
        if (wa_vld_p0 && wa_addr == a) begin
          d  = wa_data;
          bz = rsv_vld_p0 && rsv_addr == a;
        end
`endif
      end
      rd_data[k*WORD_LENGTH +: WORD_LENGTH] = d;
      rd_busy[k] = bz;
    end
  end

endmodule

// File: tb/tb_multiport_register_file.sv
module tb_multiport_register_file;
  localparam int W   = 32;
  localparam int IDL = 5;
  localparam int NR  = 24;   // smaller than 2**IDL, so out-of-range indices get exercised
  localparam int NRD = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NRD*IDL-1:0] rd_addr;
  logic [NRD*W-1:0]   rd_data;
  logic [NRD-1:0]     rd_busy;
  logic               wa_en, wb_en, rsv_en;
  logic [IDL-1:0]     wa_addr, wb_addr, rsv_addr;
  logic [W-1:0]       wa_data, wb_data;
  logic [IDL:0]       busy_cnt;
  logic               wr_err;

  multiport_register_file #(
    .WORD_LENGTH(W), .ID_LENGTH(IDL), .NUM_REGS(NR), .NUM_READ(NRD)
  ) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_cnt(busy_cnt), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  // Behavioural reference model of the register file.
  logic [W-1:0] m_regs [32];
  bit           m_busy [32];
  bit           m_err;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  function automatic bit legal(input logic [IDL-1:0] a);
    return (a != 0) && (int'(a) < NR);
  endfunction

  function automatic logic [W-1:0] rdp(input int k);
    return rd_data[k*W +: W];
  endfunction

  function automatic logic [IDL-1:0] rap(input int k);
    return rd_addr[k*IDL +: IDL];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 0;
    end
    m_err = 0;
  endtask

  // Expected read result for index a, given the current inputs.
  task automatic model_read(input logic [IDL-1:0] a, output logic [W-1:0] d, output bit b);
    d = '0;
    b = 0;
    if (legal(a)) begin
      d = m_regs[a];
      b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
      if (wa_en && wa_addr == a) begin
        d = wa_data;
        b = rsv_en && rsv_addr == a;
      end else if (wb_en && wb_addr == a) begin
        d = wb_data;
        b = rsv_en && rsv_addr == a;
      end
`endif
    end
  endtask

  // Compare every DUT output against the model.
  task automatic compare_all();
    logic [W-1:0] d;
    bit b;
    int cnt;
    for (int k = 0; k < NRD; k++) begin
      model_read(rap(k), d, b);
      chk($sformatf("rd_data[%0d]", k), 64'(rdp(k)), 64'(d));
      chk($sformatf("rd_busy[%0d]", k), 64'(rd_busy[k]), 64'(b));
    end
    cnt = 0;
    for (int i = 0; i < 32; i++) cnt += int'(m_busy[i]);
    chk("busy_cnt", 64'(busy_cnt), 64'(cnt));
    chk("wr_err", 64'(wr_err), 64'(m_err));
  endtask

  // Advance the model by one clock edge, using the current inputs.
  task automatic model_step();
    bit a_ok, b_ok, r_ok;
    a_ok = wa_en && legal(wa_addr);
    b_ok = wb_en && legal(wb_addr);
    r_ok = rsv_en && legal(rsv_addr);
    if (a_ok && !m_busy[wa_addr] && !(r_ok && rsv_addr == wa_addr)) m_err = 1;
    if (b_ok && !m_busy[wb_addr] && !(r_ok && rsv_addr == wb_addr)) m_err = 1;
    if (b_ok) m_regs[wb_addr] = wb_data;
    if (a_ok) m_regs[wa_addr] = wa_data;   // port A wins on a double hit
    if (a_ok) m_busy[wa_addr] = 0;
    if (b_ok) m_busy[wb_addr] = 0;
    if (r_ok) m_busy[rsv_addr] = 1;        // a reservation outranks a write clear
  endtask

  // Called just after a rising edge: check at the falling edge,
  // update the model, then step past the next rising edge.
  task automatic cycle();
    @(negedge clk);
    compare_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    wa_en = 0; wb_en = 0; rsv_en = 0;
    wa_addr = '0; wb_addr = '0; rsv_addr = '0;
    wa_data = '0; wb_data = '0;
  endtask

  task automatic set_rd(input logic [IDL-1:0] a0, input logic [IDL-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  // Asynchronous reset pulse, checked before any clock edge can occur.
  task automatic do_reset();
    set_idle();
    rst = 1;
    #1;
    model_reset();
    chk("rst rd_data0", 64'(rdp(0)), 64'h0);
    chk("rst rd_data1", 64'(rdp(1)), 64'h0);
    chk("rst busy_cnt", 64'(busy_cnt), 64'h0);
    chk("rst wr_err", 64'(wr_err), 64'h0);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_idle();
    set_rd(5'd0, 5'd0);
    #2;
    do_reset();

    // Write to a register that is not busy: wr_err sets and stays set.
    wb_en = 1; wb_addr = 5'd9; wb_data = 32'h1;
    cycle();
    set_idle(); set_rd(5'd9, 5'd0); #1;
    chk("wr_err set", 64'(wr_err), 64'h1);
    chk("R9 value", 64'(rdp(0)), 64'h1);
    cycle(); cycle(); cycle();
    chk("wr_err sticky", 64'(wr_err), 64'h1);

    // Reset mid-run clears data that was written just before.
    wa_en = 1; wa_addr = 5'd5; wa_data = 32'hDEAD;
    cycle();
    set_idle(); set_rd(5'd5, 5'd9); #1;
    chk("R5 before rst", 64'(rdp(0)), 64'hDEAD);
    do_reset();

    // A basic write, then a write to R0, which must be dropped.
    wa_en = 1; wa_addr = 5'd3; wa_data = 32'h1234;
    cycle();
    set_idle(); set_rd(5'd3, 5'd0); #1;
    chk("R3 write", 64'(rdp(0)), 64'h1234);
    wa_en = 1; wa_addr = 5'd0; wa_data = 32'hFFFF;
    cycle();
    set_idle(); #1;
    chk("R0 zero", 64'(rdp(1)), 64'h0);

    // Both ports target the same register: port A wins.
    wa_en = 1; wa_addr = 5'd7; wa_data = 32'hAAAA;
    wb_en = 1; wb_addr = 5'd7; wb_data = 32'h5555;
    cycle();
    set_idle(); set_rd(5'd7, 5'd8); #1;
    chk("R7 A wins", 64'(rdp(0)), 64'hAAAA);
    wb_en = 1; wb_addr = 5'd8; wb_data = 32'h5555;
    cycle();
    set_idle(); #1;
    chk("R8 B alone", 64'(rdp(1)), 64'h5555);

    // Scoreboard: reserve, clear by a write, then reserve and write together.
    rsv_en = 1; rsv_addr = 5'd4; set_rd(5'd4, 5'd0);
    cycle();
    set_idle(); #1;
    chk("R4 busy", 64'(rd_busy[0]), 64'h1);
    chk("cnt 1", 64'(busy_cnt), 64'h1);
    wa_en = 1; wa_addr = 5'd4; wa_data = 32'h42;
    cycle();
    set_idle(); #1;
    chk("R4 free", 64'(rd_busy[0]), 64'h0);
    chk("cnt 0", 64'(busy_cnt), 64'h0);
    rsv_en = 1; rsv_addr = 5'd4; wa_en = 1; wa_addr = 5'd4; wa_data = 32'h43;
    cycle();
    set_idle(); #1;
    chk("R4 rsv wins", 64'(rd_busy[0]), 64'h1);
    chk("R4 data", 64'(rdp(0)), 64'h43);
    // Writing an index >= NUM_REGS is dropped and does not flag an error.
    do_reset();
    wa_en = 1; wa_addr = 5'd30; wa_data = 32'h9;
    set_rd(5'd30, 5'd0);
    cycle();
    set_idle(); #1;
    chk("oob wr_err", 64'(wr_err), 64'h0);
    chk("oob read", 64'(rdp(0)), 64'h0);

    // Same-cycle forwarding (or its absence) from a write to a read.
    wa_en = 1; wa_addr = 5'd2; wa_data = 32'h11;
    cycle();
    set_idle();
    wa_en = 1; wa_addr = 5'd2; wa_data = 32'h77; set_rd(5'd0, 5'd2); #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass same cycle", 64'(rdp(1)), 64'h77);
`else
    chk("no bypass old", 64'(rdp(1)), 64'h11);
`endif
    cycle();
    set_idle(); #1;
    chk("R2 next cycle", 64'(rdp(1)), 64'h77);

    // Randomized traffic, checked against the model every cycle.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end
      wa_en    = ($urandom_range(0, 99) < 40);
      wb_en    = ($urandom_range(0, 99) < 40);
      rsv_en   = ($urandom_range(0, 99) < 35);
      wa_addr  = IDL'($urandom_range(0, 31));
      wb_addr  = ($urandom_range(0, 3) == 0) ? wa_addr : IDL'($urandom_range(0, 31));
      rsv_addr = ($urandom_range(0, 4) == 0) ? wa_addr : IDL'($urandom_range(0, 31));
      wa_data  = $urandom;
      wb_data  = $urandom;
      set_rd(($urandom_range(0, 2) == 0) ? wa_addr : IDL'($urandom_range(0, 31)),
             ($urandom_range(0, 2) == 0) ? wb_addr : IDL'($urandom_range(0, 31)));
      cycle();
    end
    set_idle();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
